// File: rtl/paillier_host_ctrl_pkg.sv
// paillier_host_ctrl_pkg: opcodes, response error codes, FSM states
// and helpers shared by the Paillier host sequencer and its watchdog.
package paillier_host_ctrl_pkg;

    localparam int PAILLIER_WIDTH = 128;

    localparam logic [3:0] OP_ENC = 4'b0001;
    localparam logic [3:0] OP_DEC = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_ARM,
        S_ISSUE,
        S_WAIT_OUT,
        S_WAIT_DONE,
        S_RESP
    } state_e;

    // A command is legal when exactly one opcode bit is set.
    function automatic logic op_legal(input logic [3:0] op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/paillier_op_watchdog.sv
// paillier_op_watchdog: cycle counter guarding one core operation.
// Ports: clk, rst (sync, active high), clr (zero the count), en (count
// this cycle), expired (high in the TIMEOUT-th enabled cycle since clr).
module paillier_op_watchdog #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // The counter saturates once expired so it can never wrap around.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = en && (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/paillier_host_ctrl.sv
// paillier_host_ctrl: runs one Paillier core operation per command.
// Ports: clk, rst (sync, active high); cmd_valid/cmd_ready/cmd_op/
// cmd_a/cmd_b command in; core_rst_n/core_number_1/core_number_2/
// core_state to the core; core_output_start/core_done/core_result from
// the core; rsp_valid/rsp_ready/rsp_data/rsp_op/rsp_err response out;
// busy while not idle. Every output is a flop.
module paillier_host_ctrl
    import paillier_host_ctrl_pkg::*;
#(
    parameter int WIDTH      = PAILLIER_WIDTH,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             core_rst_n,
    output logic [WIDTH-1:0] core_number_1,
    output logic [WIDTH-1:0] core_number_2,
    output logic [3:0]       core_state,
    input  logic             core_output_start,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_op,
    output logic [1:0]       rsp_err,
    output logic             busy
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e state_q;
    state_e state_nx;
    logic [1:0] err_nx;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [RCW-1:0]   rcnt_q;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    logic             cmd_ready_d;
    logic             core_rst_n_d;
    logic [WIDTH-1:0] num1_d;
    logic [WIDTH-1:0] num2_d;
    logic [3:0]       core_state_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_d;
    logic [3:0]       rsp_op_d;
    logic [1:0]       rsp_err_d;
    logic             busy_d;

    // The count starts fresh in ARM, so ISSUE is the first counted cycle.
    assign wd_clr = (state_q == S_ARM);
    assign wd_en  = (state_q == S_ISSUE) || (state_q == S_WAIT_OUT) ||
                    (state_q == S_WAIT_DONE);

    paillier_op_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        err_nx   = ERR_OK;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (op_legal(cmd_op)) begin
                        state_nx = S_CRST;
                    end else begin
                        state_nx = S_RESP;
                        err_nx   = ERR_ILLEGAL;
                    end
                end
            end
            S_CRST: begin
                if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                    state_nx = S_ARM;
                end
            end
            S_ARM:   state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT_OUT;
            S_WAIT_OUT: begin
                // A completion wins over a watchdog expiry in the same cycle.
                if (core_output_start && core_done) begin
                    state_nx = S_RESP;
                end else if (core_output_start) begin
                    state_nx = S_WAIT_DONE;
                end else if (core_done || wd_expired) begin
                    // done without any result is treated like a hang
                    state_nx = S_RESP;
                    err_nx   = ERR_TIMEOUT;
                end
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    state_nx = S_RESP;
                end else if (wd_expired) begin
                    state_nx = S_RESP;
                    err_nx   = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output values are decoded from the next state and then registered,
    // so each output lines up with the state it belongs to.
    always_comb begin
        cmd_ready_d  = (state_nx == S_IDLE);
        busy_d       = (state_nx != S_IDLE);
        core_rst_n_d = (state_nx != S_CRST);
        num1_d       = '0;
        num2_d       = '0;
        core_state_d = '0;
        rsp_valid_d  = (state_nx == S_RESP);
        rsp_data_d   = '0;
        rsp_op_d     = '0;
        rsp_err_d    = ERR_OK;
        if (state_nx == S_ISSUE) begin
            num1_d = a_q;
            num2_d = b_q;
        end
        if ((state_nx == S_ISSUE) || (state_nx == S_WAIT_OUT) ||
            (state_nx == S_WAIT_DONE)) begin
            core_state_d = op_q;
        end
        if (state_nx == S_RESP) begin
            if (state_q == S_RESP) begin
                rsp_data_d = rsp_data;
                rsp_op_d   = rsp_op;
                rsp_err_d  = rsp_err;
            end else begin
                // Illegal ops go straight from IDLE, before op_q is loaded.
                rsp_op_d  = (state_q == S_IDLE) ? cmd_op : op_q;
                rsp_err_d = err_nx;
                if (err_nx == ERR_OK) begin
                    // Same-cycle start+done has not reached res_q yet.
                    rsp_data_d = (state_q == S_WAIT_OUT) ? core_result : res_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            rcnt_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && cmd_valid) begin
                op_q <= cmd_op;
                a_q  <= cmd_a;
                b_q  <= cmd_b;
            end
            if ((state_q == S_WAIT_OUT) && core_output_start) begin
                res_q <= core_result;
            end
            if (state_q == S_CRST) begin
                rcnt_q <= rcnt_q + RCW'(1);
            end else begin
                rcnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            core_rst_n    <= 1'b0;
            core_number_1 <= '0;
            core_number_2 <= '0;
            core_state    <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_op        <= '0;
            rsp_err       <= ERR_OK;
        end else begin
            cmd_ready     <= cmd_ready_d;
            busy          <= busy_d;
            core_rst_n    <= core_rst_n_d;
            core_number_1 <= num1_d;
            core_number_2 <= num2_d;
            core_state    <= core_state_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data      <= rsp_data_d;
            rsp_op        <= rsp_op_d;
            rsp_err       <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_paillier_host_ctrl.sv
// tb_paillier_host_ctrl: drives paillier_host_ctrl against a fixed-latency
// core model and checks responses against a command-level reference.
module tb_paillier_host_ctrl;
    import paillier_host_ctrl_pkg::*;

    localparam int W       = 128;
    localparam int RST_CYC = 2;
    localparam int TMO     = 64;
    localparam int LAT     = 5;

    localparam int M_NORMAL = 0;
    localparam int M_SAME   = 1;
    localparam int M_NEVER  = 2;
    localparam int M_DONLY  = 3;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           mode;
        int           stall;
        logic [1:0]   exp_err;
        logic [W-1:0] exp_data;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         core_rst_n;
    logic [W-1:0] core_number_1;
    logic [W-1:0] core_number_2;
    logic [3:0]   core_state;
    logic         core_output_start;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_op;
    logic [1:0]   rsp_err;
    logic         busy;

    int n_pass;
    int n_total;
    int model_mode;
    bit spur;

    paillier_host_ctrl #(
        .WIDTH      (W),
        .RST_CYCLES (RST_CYC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_a             (cmd_a),
        .cmd_b             (cmd_b),
        .core_rst_n        (core_rst_n),
        .core_number_1     (core_number_1),
        .core_number_2     (core_number_2),
        .core_state        (core_state),
        .core_output_start (core_output_start),
        .core_done         (core_done),
        .core_result       (core_result),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_op            (rsp_op),
        .rsp_err           (rsp_err),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Known results of the modelled core.
    function automatic logic [W-1:0] core_fn(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            OP_ENC:  return a * 128'd65537 + b;
            OP_DEC:  return a ^ 128'h5a5a;
            OP_ADD:  return a * b;
            default: return a + b * 128'd3;
        endcase
    endfunction

    // Command-level reference: what the requester should get back.
    function automatic vec_t mk_vec(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input int mode,
                                    input int stall);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.mode = mode; v.stall = stall;
        if (!$onehot(op)) begin
            v.exp_err = 2'b01; v.exp_data = '0;
        end else if (mode == M_NEVER || mode == M_DONLY) begin
            v.exp_err = 2'b10; v.exp_data = '0;
        end else begin
            v.exp_err = 2'b00; v.exp_data = core_fn(op, a, b);
        end
        return v;
    endfunction

    // Cycles from the ISSUE cycle to the first rsp_valid cycle.
    function automatic int exp_lat(input int mode);
        case (mode)
            M_NORMAL: return LAT + 2;
            M_NEVER:  return TMO;
            default:  return LAT + 1;
        endcase
    endfunction

    // Core model: after LAT cycles from the operand cycle it answers
    // according to model_mode. core_result carries noise otherwise.
    int           m_cnt;
    bit           m_done_next;
    logic [3:0]   m_prev;
    logic [3:0]   m_op;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;

    initial begin
        core_output_start = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        m_cnt = -1; m_done_next = 1'b0; m_prev = '0;
        m_op = '0; m_a = '0; m_b = '0;
    end

    always @(negedge clk) begin
        core_output_start = 1'b0;
        core_done = 1'b0;
        core_result = rand128();
        if (spur) begin
            core_output_start = 1'b1;
            core_done = 1'b1;
        end else if (!core_rst_n) begin
            m_cnt = -1;
            m_done_next = 1'b0;
        end else begin
            if (m_done_next) begin
                core_done = 1'b1;
                m_done_next = 1'b0;
            end
            if (core_state != 4'd0 && m_prev == 4'd0) begin
                m_cnt = LAT;
                m_op = core_state; m_a = core_number_1; m_b = core_number_2;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_cnt = -1;
                    case (model_mode)
                        M_NORMAL: begin
                            core_output_start = 1'b1;
                            core_result = core_fn(m_op, m_a, m_b);
                            m_done_next = 1'b1;
                        end
                        M_SAME: begin
                            core_output_start = 1'b1;
                            core_done = 1'b1;
                            core_result = core_fn(m_op, m_a, m_b);
                        end
                        M_DONLY: core_done = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
        m_prev = core_state;
    end

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic run_cmd(input vec_t v);
        int rl, issues, iss_cyc, rsp_cyc, waitc;
        logic [W-1:0] ia, ib, a_after, b_after;
        logic [3:0] io, cs_after, prev_cs;
        bit legal;
        legal = $onehot(v.op);
        model_mode = v.mode;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom); cmd_a = rand128(); cmd_b = rand128();
        rl = 0; issues = 0; iss_cyc = -1; rsp_cyc = -1; prev_cs = '0;
        ia = '0; ib = '0; io = '0; a_after = '1; b_after = '1; cs_after = '0;
        for (int c = 0; c < 300; c++) begin
            if (!core_rst_n) rl++;
            if (iss_cyc >= 0 && c == iss_cyc + 1) begin
                a_after = core_number_1; b_after = core_number_2;
                cs_after = core_state;
            end
            if (core_state != 4'd0 && prev_cs == 4'd0) begin
                issues++; iss_cyc = c;
                ia = core_number_1; ib = core_number_2; io = core_state;
            end
            prev_cs = core_state;
            if (rsp_valid) begin
                rsp_cyc = c;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen_in_budget", rsp_cyc >= 0, 1);
        if (rsp_cyc < 0) return;
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_err", rsp_err, v.exp_err);
        check("rsp_op", rsp_op, v.op);
        if (legal) begin
            check("core_rst_low_cycles", rl, RST_CYC);
            check("issue_count", issues, 1);
            check("accept_to_issue", iss_cyc, RST_CYC + 1);
            check("issue_op", io, v.op);
            check("issue_a", ia, v.a);
            if (v.op != OP_DEC) check("issue_b", ib, v.b);
            check("operands_zero_after_issue", a_after | b_after, 0);
            check("core_state_held_wait", cs_after, v.op);
            check("issue_to_rsp", rsp_cyc - iss_cyc, exp_lat(v.mode));
        end else begin
            check("illegal_core_rst_low", rl, 0);
            check("illegal_no_issue", issues, 0);
            check("illegal_immediate_rsp", rsp_cyc, 0);
        end
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, v.exp_data);
            check("stall_err_op", {rsp_err, rsp_op}, {v.exp_err, v.op});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_after_handshake", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    vec_t tbl[10];
    vec_t rv;
    bit   saw_valid;
    logic [3:0] rop;

    initial begin
        n_pass = 0; n_total = 0; spur = 1'b0; model_mode = M_NORMAL;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_core_state", core_state, 0);
        check("rst_core_numbers", core_number_1 | core_number_2, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_op_err", {rsp_op, rsp_err}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_core_rst_n", core_rst_n, 1);

        tbl[0] = mk_vec(OP_ENC, 8, 3, M_NORMAL, 0);
        tbl[1] = mk_vec(OP_DEC, 33524, 0, M_NORMAL, 0);
        tbl[2] = mk_vec(OP_ADD, 226, 3409, M_NORMAL, 0);
        tbl[3] = mk_vec(OP_MUL, 10, 226, M_NORMAL, 0);
        tbl[4] = mk_vec(4'b0011, 17, 19, M_NORMAL, 0);
        tbl[5] = mk_vec(4'b0000, 23, 29, M_NORMAL, 0);
        tbl[6] = mk_vec(OP_ENC, 41, 43, M_NEVER, 0);
        tbl[7] = mk_vec(OP_ADD, 77, 99, M_NORMAL, 0);
        tbl[8] = mk_vec(OP_MUL, 5, 7, M_SAME, 10);
        tbl[9] = mk_vec(OP_DEC, 1234, 55, M_DONLY, 0);
        for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

        // Stray core pulses while idle must be ignored.
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        check("spur_idle_state", {rsp_valid, busy, cmd_ready}, 3'b001);

        // Reset while waiting on the core.
        model_mode = M_NEVER;
        cmd_op = OP_ADD; cmd_a = 5; cmd_b = 6; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (RST_CYC + 3) @(negedge clk);
        check("pre_rst_wait_out", {busy, core_state}, {1'b1, OP_ADD});
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_core_rst_n", core_rst_n, 0);
        check("midrst_core_outs", {core_state, core_number_1 | core_number_2}, 0);
        check("midrst_rsp", {rsp_valid, rsp_data, rsp_op, rsp_err, busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("after_midrst_ready", {cmd_ready, core_rst_n}, 2'b11);
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("no_rsp_after_abort", saw_valid, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 6) == 0) rop = 4'($urandom);
            else rop = 4'(1 << $urandom_range(0, 3));
            rv = mk_vec(rop, rand128(), rand128(),
                        ($urandom_range(0, 7) == 0) ? M_DONLY :
                        int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/paillier_host_ctrl.md
# paillier_host_ctrl

Host-side command sequencer that drives the Paillier operation core (encrypt, decrypt, homomorphic add, homomorphic multiply) on behalf of an upstream requester. It accepts one command at a time over a valid/ready interface, resets and arms the core, presents operands for exactly one cycle, and waits for `output_start` and `done`. It returns the captured 128-bit result over a valid/ready response interface, flagging illegal opcodes and core time-outs. It sits between the system command bus and the core, replacing the bench-driven stimulus used for latency characterisation.

## Interface
Parameters:
- `WIDTH`, 128, operand/result width
- `RST_CYCLES`, 2, cycles `core_rst_n` is held low per command (min 1)
- `TIMEOUT`, 1_000_000, max cycles from ISSUE to `core_done` before abort

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_op`  in  4  one-hot: 0001 enc, 0010 dec, 0100 add, 1000 mul
- `cmd_a`, `cmd_b`  in  WIDTH  operands (`cmd_b` ignored for dec)
- `core_rst_n`  out  1  core reset, active low
- `core_number_1`, `core_number_2`  out  WIDTH  core operands
- `core_state`  out  4  core opcode
- `core_output_start`  in  1  result valid on `core_result` this cycle
- `core_done`  in  1  core finished
- `core_result`  in  WIDTH  core result
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts
- `rsp_data`  out  WIDTH  captured result (0 on error)
- `rsp_op`  out  4  echo of `cmd_op`
- `rsp_err`  out  2  00 ok, 01 illegal op, 10 timeout
- `busy`  out  1  state != IDLE

## Operation
- FSM: IDLE, CRST, ARM, ISSUE, WAIT_OUT, WAIT_DONE, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch op/a/b. Legal op (exactly one bit set) -> CRST. Illegal op -> RESP with `rsp_err`=01, `rsp_data`=0; core is not touched.
- CRST: `core_rst_n`=0 for RST_CYCLES cycles, `core_state`=0, operands 0 -> ARM.
- ARM: `core_rst_n`=1, `core_state`=0, one cycle -> ISSUE.
- ISSUE: one cycle; drive latched a/b on `core_number_1/2` and op on `core_state` -> WAIT_OUT. Watchdog starts counting.
- WAIT_OUT: operands forced to 0; `core_state` holds op. On `core_output_start`, capture `core_result`. If `core_done` is also high that cycle -> RESP, otherwise -> WAIT_DONE.
- WAIT_DONE: on `core_done` -> RESP.
- Watchdog reaches TIMEOUT in WAIT_OUT or WAIT_DONE -> RESP with `rsp_err`=10, `rsp_data`=0. Any partially captured result is discarded.
- `core_done` seen in WAIT_OUT without a prior `core_output_start` is a timeout-class error: `rsp_err`=10.
- RESP: `rsp_valid`=1, `core_state`=0. Data, op and err stay stable until `rsp_ready`. On the handshake -> IDLE.
- `core_output_start` or `core_done` pulses outside WAIT_OUT/WAIT_DONE are ignored.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after. `core_rst_n`=0 while `rst` is high. Core operands, `core_state`, `rsp_valid`, `rsp_data`, `rsp_op`, `rsp_err` and `busy` are all 0. FSM goes to IDLE and the watchdog clears.
- `rst` mid-operation aborts immediately. No response is produced, and the core is held in reset through the `rst` cycle.
- Command accept to ISSUE: RST_CYCLES+1 cycles. ISSUE lasts exactly one cycle.
- Result capture happens in the `core_output_start` cycle. `rsp_valid` rises on the cycle after `core_done` is sampled.
- Back-to-back: `cmd_ready` rises the cycle after the response handshake, so the minimum per-op overhead is RST_CYCLES+4 cycles plus core latency.
- All outputs are registered. No combinational path from `cmd_*` or `core_*` to any output.

## Structure
- Opcode constants OP_ENC/OP_DEC/OP_ADD/OP_MUL, WIDTH, and the `rsp_err` codes go in the shared `_parameter.v`.
- One sub-module: `paillier_op_watchdog` (clear/enable/expire counter, width from `$clog2(TIMEOUT+1)`).
- FSM, operand/result registers and the handshake logic stay in `paillier_host_ctrl`.

## Test plan
The bench uses a behavioural core model with fixed latency L and known results.
- Enc: op=0001, a=8, b=3 -> exactly one ISSUE cycle carrying 8/3. `rsp_data` equals the model result, `rsp_err`=00, `rsp_op`=0001.
- Dec then add then mul, back-to-back: (33524,0,0010), (226,3409,0100), (10,226,1000) -> three in-order responses. Before each ISSUE, `core_rst_n` is low for RST_CYCLES cycles.
- Illegal op 0011 and op 0000 -> immediate response with `rsp_err`=01 and `rsp_data`=0. `core_rst_n` never pulses.
- Model never asserts done with TIMEOUT=64 -> `rsp_err`=10 exactly 64 cycles after ISSUE. The next command then completes normally.
- `core_output_start` and `core_done` in the same cycle -> result captured and RESP the next cycle. Holding `rsp_ready`=0 for 10 cycles keeps `rsp_*` stable.
- Assert `rst` in WAIT_OUT -> next cycle all outputs are at reset values, with no `rsp_valid`.
